mult_seq_arbiter: RTL

Sequential sign-magnitude multiplier with a two-port round-robin front end. Two requesters share one shift-and-add multiply datapath. Operands use the team's sign-magnitude format: MSB is the sign, the lower bits are the magnitude. Results are returned as two's complement with a requester tag, and the block is the shared multiply resource behind the display/ALU paths.

---
 rtl/mult_seq_arbiter.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mult_seq_arbiter.sv
// ----------------------------------------------------------------------------
// mult_seq_arbiter
//
// Shared sequential sign-magnitude multiplier with a two-port round-robin
// front end. Each requester presents two sign-magnitude operands (MSB = sign,
// low MAG_W bits = magnitude). The winning requester's operands are latched.
// The magnitudes are multiplied by shift-and-add, one multiplier bit per
// cycle. The product is returned in two's complement, tagged with the index
// of the requester that issued it.
//
// Ports
//   clk                      single clock, rising edge
//   rst_n                    synchronous active-low reset
//   req0_valid / req1_valid  requester has an operation pending
//   req0_a/_b, req1_a/_b     operands, [MAG_W] sign, [MAG_W-1:0] magnitude
//   req0_ready / req1_ready  operation accepted this cycle (combinational)
//   res_valid                result available (held until res_ready)
//   res_data                 product, 2*MAG_W+1 bits two's complement
//   res_id                   index of the requester that issued the operation
//   res_ready                consumer accepts the result
//   busy                     high whenever the FSM is not idle
// ----------------------------------------------------------------------------
module mult_seq_arbiter #(
    parameter int MAG_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               req0_valid,
    input  logic [MAG_W:0]     req0_a,
    input  logic [MAG_W:0]     req0_b,
    output logic               req0_ready,

    input  logic               req1_valid,
    input  logic [MAG_W:0]     req1_a,
    input  logic [MAG_W:0]     req1_b,
    output logic               req1_ready,

    output logic               res_valid,
    output logic [2*MAG_W:0]   res_data,
    output logic               res_id,
    input  logic               res_ready,

    output logic               busy
);

    localparam int RES_W  = 2 * MAG_W + 1;
    localparam int ACC_W  = 2 * MAG_W;
    // step counts 0..MAG_W, so it needs room for the value MAG_W itself
    localparam int STEP_W = (MAG_W < 2) ? 1 : $clog2(MAG_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_q,      state_d;
    logic                 last_grant_q, last_grant_d;
    logic [MAG_W-1:0]     a_mag_q,      a_mag_d;
    logic [MAG_W-1:0]     b_mag_q,      b_mag_d;
    logic                 sign_q,       sign_d;
    logic                 id_q,         id_d;
    logic [ACC_W-1:0]     acc_q,        acc_d;
    logic [STEP_W-1:0]    step_q,       step_d;
    logic                 res_valid_q,  res_valid_d;
    logic [RES_W-1:0]     res_data_q,   res_data_d;
    logic                 res_id_q,     res_id_d;
    logic                 busy_q,       busy_d;

    // ------------------------------------------------------------------
    // Front end: arbitration and ready generation
    // ------------------------------------------------------------------
    logic [1:0]           req_valid;
    logic [1:0]           grant;
    logic [1:0]           req_ready;
    logic                 accept;
    logic                 accept_id;
    logic [MAG_W:0]       sel_a;
    logic [MAG_W:0]       sel_b;

    assign req_valid = {req1_valid, req0_valid};

    // On a tie the requester that did not win last time gets the grant,
    // so a pending requester can lose at most one tie in a row.
    assign grant[0] = req_valid[0] & (~req_valid[1] |  last_grant_q);
    assign grant[1] = req_valid[1] & (~req_valid[0] | ~last_grant_q);

    // Readies are forced low while reset is asserted, even though the
    // state register may already read IDLE during a multi-cycle reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = rst_n & (state_q == ST_IDLE)
                                 & req_valid[gi] & grant[gi];
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    assign accept    = |req_ready;
    assign accept_id = req_ready[1];
    assign sel_a     = accept_id ? req1_a : req0_a;
    assign sel_b     = accept_id ? req1_b : req0_b;

    // ------------------------------------------------------------------
    // Datapath: pre-shifted copies of the multiplicand, one per step
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]     pp [MAG_W];
    logic [ACC_W-1:0]     addend;
    logic [RES_W-1:0]     mag_ext;

    generate
        for (genvar gi = 0; gi < MAG_W; gi++) begin : g_pp
            assign pp[gi] = ACC_W'(a_mag_q) << gi;
        end
    endgenerate

    // Pick the partial product for the current step, gated by the
    // corresponding multiplier bit.
    always_comb begin
        addend = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if ((step_q == STEP_W'(i)) && b_mag_q[i]) begin
                addend = pp[i];
            end
        end
    end

    assign mag_ext = {1'b0, acc_q};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_mag_d      = a_mag_q;
        b_mag_d      = b_mag_q;
        sign_d       = sign_q;
        id_d         = id_q;
        acc_d        = acc_q;
        step_d       = step_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_mag_d      = sel_a[MAG_W-1:0];
                    b_mag_d      = sel_b[MAG_W-1:0];
                    sign_d       = sel_a[MAG_W] ^ sel_b[MAG_W];
                    id_d         = accept_id;
                    acc_d        = '0;
                    step_d       = '0;
                    last_grant_d = accept_id;
                    state_d      = ST_MUL;
                end
            end

            ST_MUL: begin
                acc_d  = acc_q + addend;
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(MAG_W - 1)) begin
                    state_d = ST_SIGN;
                end
            end

            ST_SIGN: begin
                // A zero magnitude never becomes negative: -0 maps to 0.
                if (sign_q && (acc_q != '0)) begin
                    res_data_d = -mag_ext;
                end else begin
                    res_data_d = mag_ext;
                end
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = ST_DONE;
            end

            ST_DONE: begin
                // Result stays frozen until the consumer takes it.
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // busy is registered from the next state so it lines up with state_q
    assign busy_d = (state_d != ST_IDLE);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            a_mag_q      <= '0;
            b_mag_q      <= '0;
            sign_q       <= 1'b0;
            id_q         <= 1'b0;
            acc_q        <= '0;
            step_q       <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_mag_q      <= a_mag_d;
            b_mag_q      <= b_mag_d;
            sign_q       <= sign_d;
            id_q         <= id_d;
            acc_q        <= acc_d;
            step_q       <= step_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            busy_q       <= busy_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;

endmodule
